// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in, one bit per
// clock, LSB first, with a single full adder and a carry flip-flop.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   request a new addition (accepted in IDLE or DONE)
//   a, b      in   WIDTH-bit operands, sampled when start is accepted
//   carryin   in   initial carry, sampled when start is accepted
//   busy      out  high while bits are being processed (RUN)
//   done      out  one-cycle pulse when a new result is valid (DONE)
//   sum       out  registered result of the last completed addition
//   carryout  out  registered carry out of bit WIDTH-1
//   overflow  out  registered two's-complement overflow
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;

    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;
    logic [WIDTH-1:0] acc_next;

    // Full adder on the current LSBs of the operand shift registers.
    assign bit_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    assign last_bit  = (count_reg == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts bit i sits at position i.
    assign acc_next  = WIDTH'({bit_sum, acc_reg} >> 1);

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
            sum       <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carryin;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here.
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= bit_carry;
                    acc_reg   <= acc_next;
                    count_reg <= count_reg + CW'(1);
                    if (last_bit) begin
                        state_reg <= DONE;
                        sum       <= acc_next;
                        carryout  <= bit_carry;
                        // carry_reg is the carry into the MSB at this point.
                        overflow  <= carry_reg ^ bit_carry;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=8). Directed scenarios followed
// by random operands; expected results come from integer arithmetic on the
// operands, not from any bit-level model.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    int compared   = 0;
    int mismatched = 0;

    // Model of the result registers: value of the last completed addition.
    logic [WIDTH-1:0] last_sum = '0;
    logic             last_co  = 1'b0;
    logic             last_ov  = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents operands with start for one cycle.
    task automatic do_start(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                            input string tag);
        start   = 1'b1;
        a       = va;
        b       = vb;
        carryin = vc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rises"}, 32'(busy), 32'd1);
        check({tag, "_hold_start"}, 32'(sum), 32'(last_sum));
    endtask

    // Called in the first busy cycle; waits for done and checks the result.
    // inject_at != 0 pulses start with a=FF,b=FF in that busy cycle.
    task automatic wait_result(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                               input int inject_at, input string tag);
        logic [8:0] total;
        int         signed_total;
        logic       exp_ov;
        int         busy_cnt;
        bit         seen;

        total        = {1'b0, va} + {1'b0, vb} + 9'(vc);
        signed_total = int'($signed(va)) + int'($signed(vb)) + int'(vc);
        exp_ov       = (signed_total > 127) || (signed_total < -128);

        busy_cnt = 1;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (inject_at != 0 && busy_cnt == inject_at) begin
                start   = 1'b1;
                a       = 8'hFF;
                b       = 8'hFF;
                carryin = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else if (busy) begin
                busy_cnt++;
                if (busy_cnt == WIDTH)
                    check({tag, "_hold_run"}, 32'(sum), 32'(last_sum));
            end
        end
        start = 1'b0;

        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(total[7:0]));
        check({tag, "_carryout"}, 32'(carryout), 32'(total[8]));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ov));
        $display("txn %s: a=%02h b=%02h cin=%0d -> sum=%02h co=%0d ov=%0d", tag, va, vb, vc,
                 sum, carryout, overflow);
        last_sum = total[7:0];
        last_co  = total[8];
        last_ov  = exp_ov;
    endtask

    initial begin
        bit         done_after_reset;
        logic [7:0] ra, rb;
        logic       rc;

        reset   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;

        // Reset takes effect without a clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carryout", 32'(carryout), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero add.
        do_start(8'h00, 8'h00, 1'b0, "zero");
        wait_result(8'h00, 8'h00, 1'b0, 0, "zero");
        @(negedge clk);
        check("zero_single_pulse", 32'(done), 32'd0);

        // Carry ripple through every bit.
        do_start(8'hFF, 8'h01, 1'b0, "ripple");
        wait_result(8'hFF, 8'h01, 1'b0, 0, "ripple");
        @(negedge clk);
        check("ripple_single_pulse", 32'(done), 32'd0);

        // Signed overflow, then back-to-back restart in the DONE cycle.
        do_start(8'h7F, 8'h01, 1'b0, "ovf");
        wait_result(8'h7F, 8'h01, 1'b0, 0, "ovf");
        do_start(8'hA5, 8'h5A, 1'b1, "b2b");
        wait_result(8'hA5, 8'h5A, 1'b1, 0, "b2b");
        @(negedge clk);
        check("b2b_single_pulse", 32'(done), 32'd0);

        // Start pulsed during the 3rd RUN cycle must be ignored.
        do_start(8'h03, 8'h04, 1'b0, "busystart");
        wait_result(8'h03, 8'h04, 1'b0, 3, "busystart");
        @(negedge clk);
        check("busystart_single_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("busystart_no_rerun", 32'(busy), 32'd0);

        // Reset in the 4th RUN cycle abandons the operation.
        do_start(8'h10, 8'h20, 1'b0, "rstmid");
        repeat (3) @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_sum", 32'(sum), 32'd0);
        check("rstmid_carryout", 32'(carryout), 32'd0);
        last_sum = '0;
        last_co  = 1'b0;
        last_ov  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_after_reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_after_reset = 1'b1;
        end
        check("rstmid_no_done_after", 32'(done_after_reset), 32'd0);
        $display("txn rstmid: operation abandoned by reset");
        do_start(8'h10, 8'h20, 1'b0, "after_rst");
        wait_result(8'h10, 8'h20, 1'b0, 0, "after_rst");
        @(negedge clk);

        // Random operands, randomly back-to-back or with an idle gap.
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            do_start(ra, rb, rc, $sformatf("rand%0d", n));
            wait_result(ra, rb, rc, 0, $sformatf("rand%0d", n));
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                check($sformatf("rand%0d_single_pulse", n), 32'(done), 32'd0);
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition using a, b and carryin.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, sampled only when start is accepted.
REQ-007 The block SHALL have port carryin, input, 1 bit: initial carry, sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result of the last completed addition.
REQ-011 The block SHALL have port carryout, output, 1 bit: registered carry out of bit WIDTH-1 of the last completed addition.
REQ-012 The block SHALL have port overflow, output, 1 bit: registered two's-complement overflow of the last completed addition.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL load a, b and carryin into internal shift and carry registers, clear the bit counter, and enter RUN.
REQ-015 In RUN, start SHALL be ignored and the captured operands SHALL NOT change.
REQ-016 Each RUN cycle SHALL process exactly one bit, LSB first, using full-adder logic: s = a_i XOR b_i XOR c; c' = majority(a_i, b_i, c).
REQ-017 The carry SHALL be held in a flip-flop between bits.
REQ-018 The partial sum SHALL shift in from the MSB so that bit i lands at position i after WIDTH shifts.
REQ-019 The block SHALL track the processed-bit count with a counter of ceil(log2(WIDTH+1)) bits.
REQ-020 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-021 On that same edge, the block SHALL update sum and carryout and set overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-022 Latency: with start captured at edge 0, done SHALL be high for exactly the cycle following edge WIDTH.
REQ-023 busy SHALL be high from edge 0 through edge WIDTH.
REQ-024 done SHALL be high only in DONE; busy SHALL be high only in RUN; busy and done SHALL never both be high.
REQ-025 From DONE, the FSM SHALL return to IDLE after one cycle if start=0, or re-enter RUN if start=1 (back-to-back operation, no idle gap).
REQ-026 sum, carryout and overflow SHALL hold their values from completion until the next completion, including throughout a subsequent RUN.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; carry beyond bit WIDTH-1 SHALL appear only on carryout.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, counter 0, internal registers 0, and busy, done, sum, carryout and overflow all 0, regardless of clk.
REQ-029 Reset asserted mid-RUN SHALL abandon the operation with no done pulse and no output update.
REQ-030 After reset deasserts, the first start SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 Zero add: a=00, b=00, carryin=0, start for 1 cycle -> busy high 8 cycles; done pulses once, in the cycle after edge 8; sum=00, carryout=0, overflow=0.
REQ-032 Carry ripple: a=FF, b=01, carryin=0 -> sum=00, carryout=1, overflow=0.
REQ-033 Signed overflow: a=7F, b=01, carryin=0 -> sum=80, carryout=0, overflow=1.
REQ-034 Start while busy: start a=03, b=04; at 3rd RUN cycle pulse start with a=FF, b=FF -> single done; sum=07, carryout=0; no second run begins.
REQ-035 Reset mid-run: start a=10, b=20; assert reset after 4 RUN cycles -> busy=0, done=0, sum=00 immediately; no done afterwards; next start with a=10, b=20 -> sum=30.
REQ-036 Back-to-back: hold start in the DONE cycle with a=A5, b=5A, carryin=1 -> busy re-asserts next cycle; then sum=00, carryout=1, overflow=0; the prior result holds until the new done.
